lbp_code_gen: RTL and testbench

Downstream consumer of the line-delay stage in the LBP pipeline. It takes three vertically aligned pixel taps per accepted pixel and assembles a 3×3 neighbourhood with column registers. It tracks the raster position, compares the eight neighbours against the centre and emits one 8-bit LBP code per interior pixel. Border pixels produce no output.

---
 rtl/lbp_pkg.sv | 17 +
 rtl/lbp_code_gen_compare8.sv | 17 +
 rtl/lbp_code_gen.sv | 108 ++++++++++
 tb/tb_lbp_code_gen.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lbp_pkg.sv
// Shared constants for the LBP pipeline: code width, default pixel width and
// the neighbour-to-code-bit mapping (clockwise from top-left).
package lbp_pkg;

    localparam int unsigned CODE_W = 8;
    localparam int unsigned PIX_W  = 8;

    localparam int unsigned BIT_TL = 0;
    localparam int unsigned BIT_T  = 1;
    localparam int unsigned BIT_TR = 2;
    localparam int unsigned BIT_R  = 3;
    localparam int unsigned BIT_BR = 4;
    localparam int unsigned BIT_B  = 5;
    localparam int unsigned BIT_BL = 6;
    localparam int unsigned BIT_L  = 7;

endpackage

// File: rtl/lbp_code_gen_compare8.sv
// Combinational LBP comparator: bit i set when neighbour i >= centre (unsigned).
module lbp_compare8 import lbp_pkg::*; #(
    parameter int unsigned WIDTH = PIX_W
) (
    input  logic [WIDTH-1:0]             centre,
    input  logic [CODE_W-1:0][WIDTH-1:0] nbr,
    output logic [CODE_W-1:0]            code_c
);

    always_comb begin
        code_c = '0;
        for (int i = 0; i < int'(CODE_W); i++) begin
            code_c[i] = (nbr[i] >= centre);
        end
    end

endmodule

// File: rtl/lbp_code_gen.sv
// 3x3 window assembly, raster tracking and two-stage LBP code generation for
// interior pixels; border pixels produce no code.
module lbp_code_gen import lbp_pkg::*; #(
    parameter int unsigned WIDTH = PIX_W,
    parameter int unsigned IMG_W = 640,
    parameter int unsigned IMG_H = 480
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ce,
    input  logic              sof,
    input  logic [WIDTH-1:0]  row_top,
    input  logic [WIDTH-1:0]  row_mid,
    input  logic [WIDTH-1:0]  row_bot,
    output logic [CODE_W-1:0] code,
    output logic              code_valid,
    output logic              eof_out
);

    localparam int unsigned XW = $clog2(IMG_W);
    localparam int unsigned YW = $clog2(IMG_H);

    logic [XW-1:0] x_q, cur_x_c, nxt_x_c;
    logic [YW-1:0] y_q, cur_y_c, nxt_y_c;
    logic          qual_c, last_c;
    logic          qual_q, last_q;

    logic [WIDTH-1:0]             win [3][3];
    logic [CODE_W-1:0][WIDTH-1:0] nbr_c;
    logic [CODE_W-1:0]            cmp_code_c;

    // Position of the pixel on the taps; sof forces (0,0) regardless of counters.
    always_comb begin
        cur_x_c = sof ? '0 : x_q;
        cur_y_c = sof ? '0 : y_q;
        nxt_x_c = cur_x_c + XW'(1);
        nxt_y_c = cur_y_c;
        if (cur_x_c == XW'(IMG_W - 1)) begin
            nxt_x_c = '0;
            nxt_y_c = (cur_y_c == YW'(IMG_H - 1)) ? '0 : cur_y_c + YW'(1);
        end
        qual_c = (cur_x_c >= XW'(2)) && (cur_y_c >= YW'(2));
        last_c = (cur_x_c == XW'(IMG_W - 1)) && (cur_y_c == YW'(IMG_H - 1));
    end

    // Stage 1: counters, window shift and qualify flags; flags drop on idle cycles.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            x_q    <= '0;
            y_q    <= '0;
            qual_q <= 1'b0;
            last_q <= 1'b0;
            for (int r = 0; r < 3; r++) begin
                for (int c = 0; c < 3; c++) begin
                    win[r][c] <= '0;
                end
            end
        end else begin
            qual_q <= ce && qual_c;
            last_q <= ce && last_c;
            if (ce) begin
                x_q <= nxt_x_c;
                y_q <= nxt_y_c;
                for (int r = 0; r < 3; r++) begin
                    win[r][0] <= win[r][1];
                    win[r][1] <= win[r][2];
                end
                win[0][2] <= row_top;
                win[1][2] <= row_mid;
                win[2][2] <= row_bot;
            end
        end
    end

    always_comb begin
        nbr_c         = '0;
        nbr_c[BIT_TL] = win[0][0];
        nbr_c[BIT_T]  = win[0][1];
        nbr_c[BIT_TR] = win[0][2];
        nbr_c[BIT_R]  = win[1][2];
        nbr_c[BIT_BR] = win[2][2];
        nbr_c[BIT_B]  = win[2][1];
        nbr_c[BIT_BL] = win[2][0];
        nbr_c[BIT_L]  = win[1][0];
    end

    lbp_compare8 #(.WIDTH(WIDTH)) u_cmp (
        .centre (win[1][1]),
        .nbr    (nbr_c),
        .code_c (cmp_code_c)
    );

    // Stage 2: runs every clk so in-flight codes drain even while ce is low.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            code       <= '0;
            code_valid <= 1'b0;
            eof_out    <= 1'b0;
        end else begin
            if (qual_q) begin
                code <= cmp_code_c;
            end
            code_valid <= qual_q;
            eof_out    <= qual_q && last_q;
        end
    end

endmodule

// File: tb/tb_lbp_code_gen.sv
// Self-checking bench for lbp_code_gen on a 4x4 frame, against an image-based LBP model.
module tb_lbp_code_gen;

    localparam int W = 4;
    localparam int H = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       ce = 1'b0;
    logic       sof = 1'b0;
    logic [7:0] row_top = '0, row_mid = '0, row_bot = '0;
    logic [7:0] code;
    logic       code_valid, eof_out;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    logic [7:0] img [H][W];
    int dx [8] = '{-1, 0, 1, 1, 1, 0, -1, -1};
    int dy [8] = '{-1, -1, -1, 0, 1, 1, 1, 0};

    logic [7:0] exp_code [$];
    bit         exp_eof  [$];
    int         exp_cyc  [$];
    logic [7:0] obs_code [$];
    logic       obs_eof  [$];
    int         obs_cyc  [$];

    lbp_code_gen #(.WIDTH(8), .IMG_W(W), .IMG_H(H)) dut (
        .clk        (clk),
        .rst        (rst),
        .ce         (ce),
        .sof        (sof),
        .row_top    (row_top),
        .row_mid    (row_mid),
        .row_bot    (row_bot),
        .code       (code),
        .code_valid (code_valid),
        .eof_out    (eof_out)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (rst && code_valid) begin
            obs_code.push_back(code);
            obs_eof.push_back(eof_out);
            obs_cyc.push_back(cyc);
        end
    end

    // Reference LBP of image pixel (cx,cy): neighbour k >= centre sets bit k.
    function automatic logic [7:0] lbp_ref(input int cx, input int cy);
        logic [7:0] r = '0;
        for (int k = 0; k < 8; k++) begin
            r[k] = (img[cy + dy[k]][cx + dx[k]] >= img[cy][cx]);
        end
        return r;
    endfunction

    function automatic void clear_queues();
        exp_code.delete(); exp_eof.delete(); exp_cyc.delete();
        obs_code.delete(); obs_eof.delete(); obs_cyc.delete();
    endfunction

    function automatic void random_img();
        for (int y = 0; y < H; y++)
            for (int x = 0; x < W; x++)
                img[y][x] = 8'($urandom);
    endfunction

    function automatic void fill_img(input logic [7:0] v);
        for (int y = 0; y < H; y++)
            for (int x = 0; x < W; x++)
                img[y][x] = v;
    endfunction

    // Feeds the first npix raster pixels of img, ce duty ce_pct %, and records expected codes.
    task automatic feed_frame(input int ce_pct, input bit use_sof, input int npix);
        int n = 0;
        int x, y;
        while (n < npix) begin
            @(negedge clk);
            if (int'($urandom_range(99)) < ce_pct) begin
                x = n % W;
                y = n / W;
                ce = 1'b1;
                sof = use_sof && (n == 0);
                row_bot = img[y][x];
                row_mid = (y >= 1) ? img[y-1][x] : 8'($urandom);
                row_top = (y >= 2) ? img[y-2][x] : 8'($urandom);
                if (x >= 2 && y >= 2) begin
                    exp_code.push_back(lbp_ref(x - 1, y - 1));
                    exp_eof.push_back((x == W - 1) && (y == H - 1));
                    exp_cyc.push_back(cyc + 2);
                end
                n++;
            end else begin
                ce = 1'b0;
                sof = 1'($urandom);
                row_top = 8'($urandom);
                row_mid = 8'($urandom);
                row_bot = 8'($urandom);
            end
        end
        @(negedge clk);
        ce = 1'b0;
        sof = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (code !== 8'h00 || code_valid !== 1'b0 || eof_out !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs: got code=%h valid=%b eof=%b expected 00/0/0", code, code_valid, eof_out);
        end
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if (code_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_idle_valid: got %b expected 0", code_valid);
        end
    endtask

    task automatic test_ramp();
        clear_queues();
        for (int y = 0; y < H; y++)
            for (int x = 0; x < W; x++)
                img[y][x] = 8'(4 * y + x);
        feed_frame(100, 1'b1, W * H);
        repeat (4) @(negedge clk);
        checks++;
        if (obs_code.size() != exp_code.size()) begin
            errors++;
            $display("FAIL ramp_count: got %0d expected %0d", obs_code.size(), exp_code.size());
        end
        for (int i = 0; i < obs_code.size() && i < exp_code.size(); i++) begin
            checks++;
            if (obs_code[i] !== 8'h78 || obs_code[i] !== exp_code[i] || obs_eof[i] !== exp_eof[i]
                || obs_cyc[i] != exp_cyc[i]) begin
                errors++;
                $display("FAIL ramp_code[%0d]: got code=%h eof=%b cyc=%0d expected code=78 eof=%b cyc=%0d",
                         i, obs_code[i], obs_eof[i], obs_cyc[i], exp_eof[i], exp_cyc[i]);
            end
        end
    endtask

    task automatic test_back_to_back_flat();
        clear_queues();
        fill_img(8'h55);
        feed_frame(100, 1'b1, W * H);
        feed_frame(100, 1'b0, W * H);
        repeat (4) @(negedge clk);
        checks++;
        if (obs_code.size() != 2 * (W - 2) * (H - 2) || obs_code.size() != exp_code.size()) begin
            errors++;
            $display("FAIL flat_count: got %0d expected %0d", obs_code.size(), 2 * (W - 2) * (H - 2));
        end
        for (int i = 0; i < obs_code.size() && i < exp_code.size(); i++) begin
            checks++;
            if (obs_code[i] !== 8'hFF || obs_eof[i] !== exp_eof[i] || obs_cyc[i] != exp_cyc[i]) begin
                errors++;
                $display("FAIL flat_code[%0d]: got code=%h eof=%b cyc=%0d expected code=ff eof=%b cyc=%0d",
                         i, obs_code[i], obs_eof[i], obs_cyc[i], exp_eof[i], exp_cyc[i]);
            end
        end
    endtask

    // Variant 0: bright centre; 1: dark centre; 2..9: one neighbour matches centre.
    task automatic test_bit_order();
        logic [7:0] first_exp;
        for (int v = 0; v < 10; v++) begin
            clear_queues();
            if (v == 0) begin
                fill_img(8'h00); img[1][1] = 8'hFF; first_exp = 8'h00;
            end else if (v == 1) begin
                fill_img(8'h01); img[1][1] = 8'h00; first_exp = 8'hFF;
            end else begin
                fill_img(8'h00); img[1][1] = 8'h01;
                img[1 + dy[v-2]][1 + dx[v-2]] = 8'h01;
                first_exp = 8'(1 << (v - 2));
            end
            feed_frame(100, 1'b1, W * H);
            repeat (4) @(negedge clk);
            checks++;
            if (obs_code.size() != exp_code.size() || obs_code.size() == 0) begin
                errors++;
                $display("FAIL bit_order_count[%0d]: got %0d expected %0d", v, obs_code.size(), exp_code.size());
            end else if (obs_code[0] !== first_exp) begin
                errors++;
                $display("FAIL bit_order_centre[%0d]: got %h expected %h", v, obs_code[0], first_exp);
            end
            for (int i = 1; i < obs_code.size() && i < exp_code.size(); i++) begin
                checks++;
                if (obs_code[i] !== exp_code[i] || obs_eof[i] !== exp_eof[i]) begin
                    errors++;
                    $display("FAIL bit_order_code[%0d.%0d]: got %h/%b expected %h/%b",
                             v, i, obs_code[i], obs_eof[i], exp_code[i], exp_eof[i]);
                end
            end
        end
    endtask

    task automatic test_random_ce();
        clear_queues();
        for (int f = 0; f < 3; f++) begin
            random_img();
            feed_frame(40, f == 0, W * H);
        end
        repeat (4) @(negedge clk);
        checks++;
        if (obs_code.size() != exp_code.size()) begin
            errors++;
            $display("FAIL random_ce_count: got %0d expected %0d", obs_code.size(), exp_code.size());
        end
        for (int i = 0; i < obs_code.size() && i < exp_code.size(); i++) begin
            checks++;
            if (obs_code[i] !== exp_code[i] || obs_eof[i] !== exp_eof[i] || obs_cyc[i] != exp_cyc[i]) begin
                errors++;
                $display("FAIL random_ce_code[%0d]: got code=%h eof=%b cyc=%0d expected code=%h eof=%b cyc=%0d",
                         i, obs_code[i], obs_eof[i], obs_cyc[i], exp_code[i], exp_eof[i], exp_cyc[i]);
            end
        end
    endtask

    // Frame A aborted after (2,2); sof lands where (3,2) would have been.
    task automatic test_sof_resync();
        clear_queues();
        random_img();
        feed_frame(100, 1'b1, 2 * W + 3);
        random_img();
        feed_frame(100, 1'b1, W * H);
        repeat (4) @(negedge clk);
        checks++;
        if (obs_code.size() != exp_code.size()) begin
            errors++;
            $display("FAIL sof_count: got %0d expected %0d", obs_code.size(), exp_code.size());
        end
        for (int i = 0; i < obs_code.size() && i < exp_code.size(); i++) begin
            checks++;
            if (obs_code[i] !== exp_code[i] || obs_eof[i] !== exp_eof[i] || obs_cyc[i] != exp_cyc[i]) begin
                errors++;
                $display("FAIL sof_code[%0d]: got code=%h eof=%b cyc=%0d expected code=%h eof=%b cyc=%0d",
                         i, obs_code[i], obs_eof[i], obs_cyc[i], exp_code[i], exp_eof[i], exp_cyc[i]);
            end
        end
    endtask

    task automatic test_async_reset();
        clear_queues();
        random_img();
        feed_frame(100, 1'b1, 2 * W + 4);
        // (2,2) code is on the outputs, (3,2) code is in flight and must be lost.
        void'(exp_code.pop_back());
        void'(exp_eof.pop_back());
        void'(exp_cyc.pop_back());
        #1 rst = 1'b0;
        #1;
        checks++;
        if (code !== 8'h00 || code_valid !== 1'b0 || eof_out !== 1'b0) begin
            errors++;
            $display("FAIL async_reset_outputs: got code=%h valid=%b eof=%b expected 00/0/0", code, code_valid, eof_out);
        end
        @(negedge clk);
        rst = 1'b1;
        random_img();
        feed_frame(100, 1'b0, W * H);
        repeat (4) @(negedge clk);
        checks++;
        if (obs_code.size() != exp_code.size()) begin
            errors++;
            $display("FAIL async_reset_count: got %0d expected %0d", obs_code.size(), exp_code.size());
        end
        for (int i = 0; i < obs_code.size() && i < exp_code.size(); i++) begin
            checks++;
            if (obs_code[i] !== exp_code[i] || obs_eof[i] !== exp_eof[i] || obs_cyc[i] != exp_cyc[i]) begin
                errors++;
                $display("FAIL async_reset_code[%0d]: got code=%h eof=%b cyc=%0d expected code=%h eof=%b cyc=%0d",
                         i, obs_code[i], obs_eof[i], obs_cyc[i], exp_code[i], exp_eof[i], exp_cyc[i]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_ramp();
        test_back_to_back_flat();
        test_bit_order();
        test_random_ce();
        test_sof_resync();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
